// File: rtl/pc_sequencer.sv
// Fetch-side PC sequencer: increment, LUT-indexed jumps, call/return stack, stall and halt.
// Optional JUMP_BYPASS_EN: combinational LUT index with single-edge jumps (no JWAIT state).
module pc_sequencer #(
    parameter int D     = 12,
    parameter int A     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stall,
    input  logic         jump_en,
    input  logic         jump_cond,
    input  logic         call_en,
    input  logic         ret_en,
    input  logic         halt_en,
    input  logic [A-1:0] jump_idx,
    input  logic [D-1:0] lut_target,
    output logic [A-1:0] lut_idx,
    output logic [D-1:0] prog_ctr,
    output logic         busy,
    output logic         done,
    output logic         fault
);

    // One extra bit so sp can represent a completely full stack.
    localparam int SPW = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        JWAIT,
        HALTED,
        FAULT
    } state_e;

    state_e         state, state_nxt;
    logic [D-1:0]   pc_nxt;
    logic [A-1:0]   idx_q, idx_nxt;
    logic [SPW-1:0] sp, sp_nxt;
    logic [SPW-2:0] wr_ptr, rd_ptr;
    logic           push;
    logic           take_jump;
    logic           stack_full;
    logic [D-1:0]   stack [DEPTH];

    assign wr_ptr     = sp[SPW-2:0];
    assign rd_ptr     = wr_ptr - (SPW-1)'(1);
    assign stack_full = (sp == SPW'(DEPTH));

    // A taken call only counts as a jump when it will not overflow the stack.
    assign take_jump = (state == RUN) && !stall && !halt_en && !ret_en &&
                       ((call_en && jump_cond) ? !stack_full : (jump_en && jump_cond));

`ifdef JUMP_BYPASS_EN
    assign lut_idx = take_jump ? jump_idx : idx_q;
`else
    assign lut_idx = idx_q;
`endif

    always_comb begin
        state_nxt = state;
        pc_nxt    = prog_ctr;
        idx_nxt   = idx_q;
        sp_nxt    = sp;
        push      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    pc_nxt    = '0;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (halt_en) begin
                        state_nxt = HALTED;
                    end else if (ret_en) begin
                        if (sp == '0) begin
                            state_nxt = FAULT;
                        end else begin
                            pc_nxt = stack[rd_ptr];
                            sp_nxt = sp - SPW'(1);
                        end
                    end else if (call_en && jump_cond && stack_full) begin
                        state_nxt = FAULT;
                    end else if (take_jump) begin
                        idx_nxt = jump_idx;
                        if (call_en) begin
                            push   = 1'b1;
                            sp_nxt = sp + SPW'(1);
                        end
`ifdef JUMP_BYPASS_EN
                        pc_nxt = lut_target;
`else
                        state_nxt = JWAIT;
`endif
                    end else begin
                        pc_nxt = prog_ctr + D'(1);
                    end
                end
            end
            JWAIT: begin
                if (!stall) begin
                    pc_nxt    = lut_target;
                    state_nxt = RUN;
                end
            end
            HALTED: begin
                if (start) begin
                    state_nxt = RUN;
                    pc_nxt    = '0;
                    sp_nxt    = '0;
                end
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Status flags are registered from the next state so they align with prog_ctr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            prog_ctr <= '0;
            idx_q    <= '0;
            sp       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state    <= state_nxt;
            prog_ctr <= pc_nxt;
            idx_q    <= idx_nxt;
            sp       <= sp_nxt;
            busy     <= (state_nxt == RUN) || (state_nxt == JWAIT);
            done     <= (state_nxt == HALTED);
            fault    <= (state_nxt == FAULT);
        end
    end

    // Stack contents need no reset; an empty sp makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            stack[wr_ptr] <= prog_ctr + D'(1);
        end
    end

endmodule
